cpu_sequencer: RTL and testbench

//   Multi-cycle run controller for the 8-bit single-issue CPU datapath. Steps each instruction

---
 rtl/cpu_pkg.sv | 16 +
 rtl/cpu_sequencer_if.sv | 13 +
 rtl/sat_counter.sv | 31 +++
 rtl/cpu_sequencer.sv | 149 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding and
// command opcodes carried on the command port.
package cpu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Command port of the run controller: a valid/ready handshake carrying
// RUN/STEP/HALT/NOP opcodes from the debug host to the sequencer.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping. Clear takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle run controller: steps each instruction through
// FETCH/EXEC/MEM/WB, gates PC/register/memory writes, handles breakpoints.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int CNT_W    = 16,
  parameter int MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  cpu_sequencer_if.slave   cmd,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             mem_access,
  output logic             ir_load,
  output logic             pc_en,
  output logic             rf_wr_gate,
  output logic             mem_wr_gate,
  output logic             busy,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] LAST_WAIT = 3'(MEM_WAIT);

  logic [2:0] state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       halt_req_q, halt_req_d;
  logic       step_mode_q, step_mode_d;
  logic       skip_bp_q, skip_bp_d;
  logic       bp_hit_q, bp_hit_d;
  logic       cnt_clr;
  logic       bp_match;
  logic       halt_cmd;

  assign cmd.cmd_ready = 1'b1;
  assign halt_cmd      = cmd.cmd_valid && (cmd.cmd_op == CMD_HALT);
  // The first FETCH after a RUN/STEP ignores the breakpoint so a resume always retires one instruction.
  assign bp_match      = bp_en && (pc == bp_addr) && !skip_bp_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    halt_req_d  = halt_req_q;
    step_mode_d = step_mode_q;
    skip_bp_d   = skip_bp_q;
    bp_hit_d    = bp_hit_q;
    cnt_clr     = 1'b0;

    if ((state_q != ST_IDLE) && halt_cmd) halt_req_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            CMD_RUN, CMD_STEP: begin
              state_d     = ST_FETCH;
              step_mode_d = (cmd.cmd_op == CMD_STEP);
              skip_bp_d   = 1'b1;
              bp_hit_d    = 1'b0;
            end
            CMD_HALT: cnt_clr = 1'b1;
            default: ;
          endcase
        end
      end
      ST_FETCH: begin
        if (bp_match) begin
          state_d    = ST_IDLE;
          bp_hit_d   = 1'b1;
          halt_req_d = 1'b0;
        end else begin
          state_d   = ST_EXEC;
          skip_bp_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (mem_access) begin
          state_d = ST_MEM;
          wait_d  = 3'd0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (wait_q == LAST_WAIT) state_d = ST_WB;
        else                     wait_d  = wait_q + 3'd1;
      end
      ST_WB: begin
        // A HALT landing in the WB cycle itself must still stop after this instruction.
        if (step_mode_q || halt_req_q || halt_cmd) begin
          state_d    = ST_IDLE;
          halt_req_d = 1'b0;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= 3'd0;
      halt_req_q  <= 1'b0;
      step_mode_q <= 1'b0;
      skip_bp_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      halt_req_q  <= halt_req_d;
      step_mode_q <= step_mode_d;
      skip_bp_q   <= skip_bp_d;
      bp_hit_q    <= bp_hit_d;
    end
  end

  // ir_load must also drop on a breakpoint FETCH, so it is the one output that looks at pc.
  assign ir_load     = (state_q == ST_FETCH) && !bp_match;
  assign pc_en       = (state_q == ST_WB);
  assign rf_wr_gate  = (state_q == ST_WB);
  assign mem_wr_gate = (state_q == ST_MEM) && (wait_q == LAST_WAIT);
  assign halted      = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign bp_hit      = bp_hit_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (state_q != ST_IDLE),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (state_q == ST_WB),
    .q     (instr_count)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle vector table for STEP timing
// plus hand-written breakpoint, halt, saturation and reset sequences.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       bp_en;
  logic [7:0] bp_addr;
  logic [7:0] pc;
  logic       mem_access;
  logic       pc_clr;

  cpu_sequencer_if cmd_a ();
  cpu_sequencer_if cmd_b ();

  logic        ir_load_a, pc_en_a, rf_a, mw_a, busy_a, halted_a, bp_hit_a;
  logic [3:0]  cyc_a, ins_a;
  logic        ir_load_b, pc_en_b, rf_b, mw_b, busy_b, halted_b, bp_hit_b;
  logic [15:0] cyc_b, ins_b;
  logic [7:0]  flags_a, flags_b;

  // Main unit: short counters for saturation, two MEM wait cycles.
  cpu_sequencer #(.PC_W(8), .CNT_W(4), .MEM_WAIT(2)) dut_a (
    .clk(clk), .reset(reset), .cmd(cmd_a.slave),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .mem_access(mem_access),
    .ir_load(ir_load_a), .pc_en(pc_en_a), .rf_wr_gate(rf_a), .mem_wr_gate(mw_a),
    .busy(busy_a), .halted(halted_a), .bp_hit(bp_hit_a),
    .cycle_count(cyc_a), .instr_count(ins_a)
  );

  cpu_sequencer #(.PC_W(8), .CNT_W(16), .MEM_WAIT(1)) dut_b (
    .clk(clk), .reset(reset), .cmd(cmd_b.slave),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .mem_access(mem_access),
    .ir_load(ir_load_b), .pc_en(pc_en_b), .rf_wr_gate(rf_b), .mem_wr_gate(mw_b),
    .busy(busy_b), .halted(halted_b), .bp_hit(bp_hit_b),
    .cycle_count(cyc_b), .instr_count(ins_b)
  );

  assign flags_a = {cmd_a.cmd_ready, ir_load_a, pc_en_a, rf_a, mw_a, busy_a, halted_a, bp_hit_a};
  assign flags_b = {cmd_b.cmd_ready, ir_load_b, pc_en_b, rf_b, mw_b, busy_b, halted_b, bp_hit_b};

  // Program counter stand-in: advances whenever the sequencer grants pc_en.
  always @(posedge clk) begin
    if (pc_clr)       pc <= 8'h00;
    else if (pc_en_a) pc <= pc + 8'h01;
  end

  localparam logic [7:0] F_IDLE  = 8'b1000_0010;
  localparam logic [7:0] F_FETCH = 8'b1100_0100;
  localparam logic [7:0] F_EXEC  = 8'b1000_0100;
  localparam logic [7:0] F_MEM   = 8'b1000_0100;
  localparam logic [7:0] F_MEMW  = 8'b1000_1100;
  localparam logic [7:0] F_WB    = 8'b1011_0100;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic       ma;
    logic [7:0] flags;
    logic [3:0] cyc;
    logic [3:0] ins;
  } vec_t;

  vec_t vecs[14];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic found;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic ma);
    cmd_a.cmd_valid = v;
    cmd_a.cmd_op    = op;
    mem_access      = ma;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // STEP without memory access, counters cleared by HALT, then STEP with a MEM phase.
    vecs[0]  = '{1'b1, CMD_STEP, 1'b0, F_IDLE,  4'd0, 4'd0};
    vecs[1]  = '{1'b0, CMD_NOP,  1'b0, F_FETCH, 4'd0, 4'd0};
    vecs[2]  = '{1'b0, CMD_NOP,  1'b0, F_EXEC,  4'd1, 4'd0};
    vecs[3]  = '{1'b0, CMD_NOP,  1'b0, F_WB,    4'd2, 4'd0};
    vecs[4]  = '{1'b0, CMD_NOP,  1'b0, F_IDLE,  4'd3, 4'd1};
    vecs[5]  = '{1'b1, CMD_HALT, 1'b0, F_IDLE,  4'd3, 4'd1};
    vecs[6]  = '{1'b1, CMD_STEP, 1'b1, F_IDLE,  4'd0, 4'd0};
    vecs[7]  = '{1'b0, CMD_NOP,  1'b1, F_FETCH, 4'd0, 4'd0};
    vecs[8]  = '{1'b0, CMD_NOP,  1'b1, F_EXEC,  4'd1, 4'd0};
    vecs[9]  = '{1'b1, CMD_STEP, 1'b1, F_MEM,   4'd2, 4'd0};
    vecs[10] = '{1'b0, CMD_NOP,  1'b1, F_MEM,   4'd3, 4'd0};
    vecs[11] = '{1'b0, CMD_NOP,  1'b1, F_MEMW,  4'd4, 4'd0};
    vecs[12] = '{1'b0, CMD_NOP,  1'b1, F_WB,    4'd5, 4'd0};
    vecs[13] = '{1'b0, CMD_NOP,  1'b0, F_IDLE,  4'd6, 4'd1};

    reset = 1'b0;
    pc_clr = 1'b1;
    bp_en = 1'b0;
    bp_addr = 8'h00;
    cmd_b.cmd_valid = 1'b0;
    cmd_b.cmd_op = CMD_NOP;
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    #3;
    checkOutput("reset_a", {flags_a, cyc_a, ins_a}, {F_IDLE, 4'd0, 4'd0});
    checkOutput("reset_b", {flags_b, cyc_b}, {F_IDLE, 16'd0});
    #20 reset = 1'b1;
    nextCycle();
    pc_clr = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].v, vecs[i].op, vecs[i].ma);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), {flags_a, cyc_a, ins_a},
                  {vecs[i].flags, vecs[i].cyc, vecs[i].ins});
      nextCycle();
    end

    // Breakpoint at 0x04: four instructions retire, then stop in FETCH.
    pc_clr = 1'b1;
    bp_en = 1'b1;
    bp_addr = 8'h04;
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    nextCycle();
    pc_clr = 1'b0;
    applyStimulus(1'b1, CMD_RUN, 1'b0);
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (halted_a) found = 1'b1;
      else nextCycle();
    end
    checkOutput("bp_stop_seen", {31'd0, found}, 32'd1);
    checkOutput("bp_hit_set", {31'd0, bp_hit_a}, 32'd1);
    checkOutput("bp_instr_count", {28'd0, ins_a}, 32'd4);
    checkOutput("bp_cycle_count", {28'd0, cyc_a}, 32'd13);
    checkOutput("bp_pc", {24'd0, pc}, 32'h04);

    // Resume from the hit: fetches 0x04 and clears bp_hit; HALT during FETCH stops after one.
    applyStimulus(1'b1, CMD_RUN, 1'b0);
    nextCycle();
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    @(negedge clk);
    checkOutput("resume_fetch", {flags_a, pc}, {F_FETCH, 8'h04});
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (halted_a) found = 1'b1;
      else nextCycle();
    end
    checkOutput("resume_stop", {flags_a, ins_a}, {F_IDLE, 4'd5});

    // HALT pulsed during EXEC of the third instruction.
    pc_clr = 1'b1;
    bp_en = 1'b0;
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    nextCycle();
    pc_clr = 1'b0;
    applyStimulus(1'b1, CMD_RUN, 1'b0);
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (ir_load_a && (ins_a == 4'd2)) found = 1'b1;
      else nextCycle();
    end
    checkOutput("halt3_fetch_seen", {31'd0, found}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    @(negedge clk);
    checkOutput("halt3_exec", {24'd0, flags_a}, {24'd0, F_EXEC});
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    @(negedge clk);
    checkOutput("halt3_wb", {24'd0, flags_a}, {24'd0, F_WB});
    nextCycle();
    @(negedge clk);
    checkOutput("halt3_idle", {flags_a, ins_a}, {F_IDLE, 4'd3});

    // HALT arriving in the WB cycle itself.
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    nextCycle();
    applyStimulus(1'b1, CMD_RUN, 1'b0);
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (pc_en_a) found = 1'b1;
      else nextCycle();
    end
    checkOutput("haltwb_wb_seen", {31'd0, found}, 32'd1);
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    @(negedge clk);
    checkOutput("haltwb_idle", {flags_a, ins_a}, {F_IDLE, 4'd1});

    // Saturation with 4-bit counters over about 20 instructions.
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    nextCycle();
    applyStimulus(1'b1, CMD_RUN, 1'b0);
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    repeat (62) nextCycle();
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (halted_a) found = 1'b1;
      else nextCycle();
    end
    checkOutput("sat_counts", {found, cyc_a, ins_a}, {1'b1, 4'd15, 4'd15});
    applyStimulus(1'b1, CMD_HALT, 1'b0);
    nextCycle();
    applyStimulus(1'b0, CMD_NOP, 1'b0);
    @(negedge clk);
    checkOutput("sat_clear", {flags_a, cyc_a, ins_a}, {F_IDLE, 4'd0, 4'd0});

    // Asynchronous reset in the last MEM cycle of a MEM_WAIT=1 unit.
    cmd_b.cmd_valid = 1'b1;
    cmd_b.cmd_op = CMD_STEP;
    mem_access = 1'b1;
    nextCycle();
    cmd_b.cmd_valid = 1'b0;
    cmd_b.cmd_op = CMD_NOP;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (mw_b) found = 1'b1;
      else nextCycle();
    end
    checkOutput("rst_mem_reached", {15'd0, found, cyc_b}, {15'd0, 1'b1, 16'd3});
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_async", {flags_b, cyc_b}, {F_IDLE, 16'd0});
    checkOutput("rst_async_ins", {16'd0, ins_b}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    mem_access = 1'b0;
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("rst_stays_idle", {flags_b, cyc_b}, {F_IDLE, 16'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
